irq_pending_unit: RTL and testbench

Interrupt front end between the external request pins and the priority encoder (PIC) that drives the CPU's `int`/`int_num`. It:
- synchronises the eight asynchronous request lines;
- latches edge-type requests into a pending register;
- applies a software mask;
- tracks in-service interrupts, so equal- and lower-priority requests are withheld from the PIC until the CPU signals end-of-interrupt.

Its `intReq` output connects directly to the PIC `intReq` input.

---
 rtl/irq_pkg.sv | 27 ++
 rtl/irq_sync.sv | 29 ++
 rtl/irq_pending_unit.sv | 107 ++++++++++
 tb/tb_irq_pending_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared interrupt constants and the lowest-set-bit helper used by the pending unit and the PIC.
package irq_pkg;

    localparam int unsigned N_IRQ = 8;
    localparam int unsigned IDX_W = $clog2(N_IRQ);

    localparam logic [N_IRQ-1:0] MASK_RST = '0;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } lowest_t;

    // Index 0 is highest priority, so the lowest set bit wins.
    function automatic lowest_t lowest_set(input logic [N_IRQ-1:0] vec);
        lowest_t res;
        res = '0;
        for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res.valid = 1'b1;
                res.idx   = IDX_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// One-bit two-flop synchroniser with a delayed copy for rising-edge detection.
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic lvl,
    output logic rise
);

    logic s1;
    logic s2;
    logic s2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= a;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~s2_d;

endmodule

// File: rtl/irq_pending_unit.sv
// Interrupt front end: synchronises requests, latches edges, masks, and withholds
// equal/lower-priority requests while an interrupt is in service.
module irq_pending_unit #(
    parameter int unsigned        N_IRQ     = 8,
    parameter int unsigned        IDX_W     = $clog2(N_IRQ),
    parameter logic [N_IRQ-1:0]   EDGE_MASK = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_raw,
    input  logic             mask_we,
    input  logic [N_IRQ-1:0] mask_wdata,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_num,
    input  logic             eoi,
    output logic [N_IRQ-1:0] intReq,
    output logic [N_IRQ-1:0] pending,
    output logic [N_IRQ-1:0] mask,
    output logic [N_IRQ-1:0] isr,
    output logic             spurious
);

    import irq_pkg::*;

    logic [N_IRQ-1:0] lvl;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] blocked;
    logic [N_IRQ-1:0] ack_oh;
    logic [N_IRQ-1:0] eoi_oh;
    logic [N_IRQ-1:0] pending_d;
    logic [N_IRQ-1:0] mask_d;
    logic [N_IRQ-1:0] isr_d;
    logic             ack_ok;
    logic             spurious_d;
    lowest_t          isr_low;

    for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
        irq_sync u_sync (
            .clk  (clk),
            .rst  (rst),
            .a    (irq_raw[g]),
            .lvl  (lvl[g]),
            .rise (rise[g])
        );
    end

    assign isr_low = lowest_set(isr);

    // Everything at or below the highest-priority in-service line is withheld.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < int'(N_IRQ); i++) begin
            blocked[i] = isr_low.valid && (IDX_W'(i) >= isr_low.idx);
        end
    end

    assign intReq = pending & mask & ~blocked;

    // Ack is validated against the current intReq, so a same-cycle mask write cannot affect it.
    always_comb begin
        ack_oh     = '0;
        eoi_oh     = '0;
        pending_d  = pending;
        mask_d     = mask;
        isr_d      = isr;
        ack_ok     = ack && intReq[ack_num];
        spurious_d = ack && !intReq[ack_num];

        if (ack_ok) begin
            ack_oh = N_IRQ'(1) << ack_num;
        end
        if (eoi && isr_low.valid) begin
            eoi_oh = N_IRQ'(1) << isr_low.idx;
        end

        // EOI retires against the old isr before the ack sets its bit.
        isr_d = (isr & ~eoi_oh) | ack_oh;

        // A fresh edge in the ack cycle wins over the ack clear.
        for (int i = 0; i < int'(N_IRQ); i++) begin
            if (EDGE_MASK[i]) begin
                pending_d[i] = (pending[i] & ~ack_oh[i]) | rise[i];
            end else begin
                pending_d[i] = lvl[i];
            end
        end

        if (mask_we) begin
            mask_d = mask_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            mask     <= MASK_RST;
            isr      <= '0;
            spurious <= 1'b0;
        end else begin
            pending  <= pending_d;
            mask     <= mask_d;
            isr      <= isr_d;
            spurious <= spurious_d;
        end
    end

endmodule

// File: tb/tb_irq_pending_unit.sv
// Directed scoreboard bench: one all-edge instance and one with line 0 level-type.
module tb_irq_pending_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] irq_raw;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic       ack;
    logic [2:0] ack_num;
    logic       eoi;

    logic [7:0] de_int_req, de_pending, de_mask, de_isr;
    logic       de_spurious;
    logic [7:0] dl_int_req, dl_pending, dl_mask, dl_isr;
    logic       dl_spurious;

    typedef struct {
        string      tag;
        logic [7:0] exp;
    } sb_t;

    sb_t sb[$];
    int  vectors     = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    irq_pending_unit #(.N_IRQ(8), .IDX_W(3), .EDGE_MASK(8'hFF)) u_de (
        .clk(clk), .rst(rst), .irq_raw(irq_raw), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .ack(ack), .ack_num(ack_num), .eoi(eoi), .intReq(de_int_req), .pending(de_pending),
        .mask(de_mask), .isr(de_isr), .spurious(de_spurious)
    );

    irq_pending_unit #(.N_IRQ(8), .IDX_W(3), .EDGE_MASK(8'hFE)) u_dl (
        .clk(clk), .rst(rst), .irq_raw(irq_raw), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .ack(ack), .ack_num(ack_num), .eoi(eoi), .intReq(dl_int_req), .pending(dl_pending),
        .mask(dl_mask), .isr(dl_isr), .spurious(dl_spurious)
    );

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp8(input string tag, input logic [7:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic chk8(input logic [7:0] obs);
        sb_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL sb_underflow observed=%02h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) else begin
                miscompares++;
                $error("FAIL %s observed=%02h expected=%02h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we    = 1'b1;
        mask_wdata = m;
        tick(1);
        mask_we    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        irq_raw    = 8'hFF;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;
        ack        = 1'b0;
        ack_num    = 3'd0;
        eoi        = 1'b0;

        // Reset with all requests high.
        exp8("rst_intreq", 8'h00);
        exp8("rst_pending", 8'h00);
        exp8("rst_mask", 8'h00);
        exp8("rst_isr", 8'h00);
        exp8("rst_spurious", 8'h00);
        do_reset(3);
        chk8(de_int_req);
        chk8(de_pending);
        chk8(de_mask);
        chk8(de_isr);
        chk8({7'd0, de_spurious});

        // Latency: pending appears on the third edge, masked off from intReq.
        exp8("lat_pending_e1", 8'h00);
        exp8("lat_pending_e2", 8'hFF);
        exp8("lat_intreq_masked", 8'h00);
        tick(2);
        chk8(de_pending);
        tick(1);
        chk8(de_pending);
        chk8(de_int_req);

        // Edge request on line 5.
        irq_raw = 8'h00;
        do_reset(2);
        exp8("mask_wr", 8'hFF);
        write_mask(8'hFF);
        chk8(de_mask);
        irq_raw = 8'h20;
        exp8("edge_e1", 8'h00);
        exp8("edge_e2", 8'h20);
        exp8("edge_held", 8'h20);
        tick(2);
        chk8(de_int_req);
        tick(1);
        chk8(de_int_req);
        tick(1);
        irq_raw = 8'h00;
        tick(2);
        chk8(de_int_req);

        exp8("ack5_intreq", 8'h00);
        exp8("ack5_isr", 8'h20);
        exp8("ack5_pending", 8'h00);
        ack = 1'b1; ack_num = 3'd5;
        tick(1);
        ack = 1'b0;
        chk8(de_int_req);
        chk8(de_isr);
        chk8(de_pending);

        // Blocking and nesting with line 5 in service.
        irq_raw = 8'h84;
        exp8("nest_intreq", 8'h04);
        exp8("nest_pending", 8'h84);
        tick(3);
        chk8(de_int_req);
        chk8(de_pending);

        exp8("nest_ack2_isr", 8'h24);
        exp8("nest_ack2_intreq", 8'h00);
        ack = 1'b1; ack_num = 3'd2;
        tick(1);
        ack = 1'b0;
        chk8(de_isr);
        chk8(de_int_req);

        exp8("nest_eoi1_isr", 8'h20);
        exp8("nest_eoi1_intreq", 8'h00);
        eoi = 1'b1;
        tick(1);
        chk8(de_isr);
        chk8(de_int_req);

        exp8("nest_eoi2_isr", 8'h00);
        exp8("nest_eoi2_intreq", 8'h80);
        tick(1);
        eoi = 1'b0;
        chk8(de_isr);
        chk8(de_int_req);

        exp8("ack7_isr", 8'h80);
        ack = 1'b1; ack_num = 3'd7;
        tick(1);
        ack = 1'b0;
        chk8(de_isr);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;

        // Spurious ack.
        exp8("spur_pulse", 8'h01);
        exp8("spur_isr", 8'h00);
        exp8("spur_pending", 8'h00);
        exp8("spur_clear", 8'h00);
        ack = 1'b1; ack_num = 3'd3;
        tick(1);
        ack = 1'b0;
        chk8({7'd0, de_spurious});
        chk8(de_isr);
        chk8(de_pending);
        tick(1);
        chk8({7'd0, de_spurious});

        // Collision: eoi and ack in the same cycle.
        irq_raw = 8'h00;
        tick(3);
        irq_raw = 8'h20;
        tick(3);
        ack = 1'b1; ack_num = 3'd5;
        tick(1);
        ack = 1'b0;
        irq_raw = 8'h22;
        exp8("col1_intreq", 8'h02);
        exp8("col1_isr", 8'h02);
        exp8("col1_pending", 8'h00);
        tick(3);
        chk8(de_int_req);
        eoi = 1'b1; ack = 1'b1; ack_num = 3'd1;
        tick(1);
        eoi = 1'b0; ack = 1'b0;
        chk8(de_isr);
        chk8(de_pending);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;

        // Collision: new rising edge on line 5 in the ack cycle.
        irq_raw = 8'h00;
        tick(3);
        irq_raw = 8'h20;
        tick(2);
        irq_raw = 8'h00;
        exp8("col2_pre", 8'h20);
        exp8("col2_pending", 8'h20);
        exp8("col2_isr", 8'h20);
        tick(3);
        chk8(de_int_req);
        irq_raw = 8'h20;
        tick(2);
        ack = 1'b1; ack_num = 3'd5;
        tick(1);
        ack = 1'b0;
        chk8(de_pending);
        chk8(de_isr);
        eoi = 1'b1;
        tick(1);
        eoi = 1'b0;

        // Level-type line 0.
        irq_raw = 8'h00;
        do_reset(2);
        write_mask(8'hFF);
        irq_raw = 8'h01;
        exp8("lvl_pending", 8'h01);
        exp8("lvl_intreq", 8'h01);
        exp8("lvl_ack_pending", 8'h01);
        exp8("lvl_ack_isr", 8'h01);
        exp8("lvl_eoi_isr", 8'h00);
        exp8("lvl_drop_pending", 8'h00);
        tick(3);
        chk8(dl_pending);
        chk8(dl_int_req);
        ack = 1'b1; ack_num = 3'd0;
        tick(1);
        ack = 1'b0;
        chk8(dl_pending);
        chk8(dl_isr);
        eoi = 1'b1;
        irq_raw = 8'h00;
        tick(1);
        eoi = 1'b0;
        chk8(dl_isr);
        tick(2);
        chk8(dl_pending);

        if (sb.size() != 0) begin
            miscompares++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
